// File: rtl/pkt_rr_arbiter.sv
// Two-input AXI-Stream packet arbiter: round-robin grant per packet, registered
// output slice, and per-requester forwarded-packet counters.
module pkt_rr_arbiter #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
    input  logic                                 clk,
    input  logic                                 aresetn,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s0_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s0_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s0_axis_tuser,
    input  logic                                 s0_axis_tvalid,
    input  logic                                 s0_axis_tlast,
    output logic                                 s0_axis_tready,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s1_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s1_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s1_axis_tuser,
    input  logic                                 s1_axis_tvalid,
    input  logic                                 s1_axis_tlast,
    output logic                                 s1_axis_tready,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
    output logic                                 m_axis_tvalid,
    output logic                                 m_axis_tlast,
    input  logic                                 m_axis_tready,

    output logic [31:0]                          pkt_cnt0,
    output logic [31:0]                          pkt_cnt1
);

    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
    localparam int UW = C_S_AXIS_TUSER_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic            last_grant_reg, last_grant_next;

    logic [DW-1:0]   m_tdata_reg, m_tdata_next;
    logic [KW-1:0]   m_tkeep_reg, m_tkeep_next;
    logic [UW-1:0]   m_tuser_reg, m_tuser_next;
    logic            m_tvalid_reg, m_tvalid_next;
    logic            m_tlast_reg, m_tlast_next;

    logic [31:0]     pkt_cnt0_reg, pkt_cnt0_next;
    logic [31:0]     pkt_cnt1_reg, pkt_cnt1_next;

    // Requester views gathered into arrays so the grant logic is per-index
    logic [1:0]      req_valid;
    logic [1:0]      req_last;
    logic [1:0]      req_ready;
    logic [1:0]      req_xfer;
    logic [1:0]      grant_onehot;
    logic [DW-1:0]   req_data [2];
    logic [KW-1:0]   req_keep [2];
    logic [UW-1:0]   req_user [2];

    logic            out_free;
    logic            sel;
    logic            in_xfer;
    logic            in_last;

    assign req_valid = {s1_axis_tvalid, s0_axis_tvalid};
    assign req_last  = {s1_axis_tlast,  s0_axis_tlast};
    assign req_data[0] = s0_axis_tdata;
    assign req_data[1] = s1_axis_tdata;
    assign req_keep[0] = s0_axis_tkeep;
    assign req_keep[1] = s1_axis_tkeep;
    assign req_user[0] = s0_axis_tuser;
    assign req_user[1] = s1_axis_tuser;

    // Output slot can take a beat when empty or draining this cycle
    assign out_free     = ~m_tvalid_reg | m_axis_tready;
    assign grant_onehot = {state_reg == GRANT1, state_reg == GRANT0};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign req_ready[gi] = grant_onehot[gi] & out_free;
            assign req_xfer[gi]  = req_ready[gi] & req_valid[gi];
        end
    endgenerate

    assign s0_axis_tready = req_ready[0];
    assign s1_axis_tready = req_ready[1];

    assign sel     = (state_reg == GRANT1);
    assign in_xfer = |req_xfer;
    assign in_last = req_last[sel];

    // Grant FSM: IDLE always costs one cycle, even with a requester waiting
    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        case (state_reg)
            IDLE: begin
                if (&req_valid)
                    state_next = last_grant_reg ? GRANT0 : GRANT1;
                else if (req_valid[0])
                    state_next = GRANT0;
                else if (req_valid[1])
                    state_next = GRANT1;
            end
            GRANT0: begin
                if (req_xfer[0] && req_last[0]) begin
                    state_next      = IDLE;
                    last_grant_next = 1'b0;
                end
            end
            GRANT1: begin
                if (req_xfer[1] && req_last[1]) begin
                    state_next      = IDLE;
                    last_grant_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output register slice; data fields simply hold once the beat drains
    always_comb begin
        m_tdata_next  = m_tdata_reg;
        m_tkeep_next  = m_tkeep_reg;
        m_tuser_next  = m_tuser_reg;
        m_tlast_next  = m_tlast_reg;
        m_tvalid_next = m_tvalid_reg;
        if (in_xfer) begin
            m_tdata_next  = req_data[sel];
            m_tkeep_next  = req_keep[sel];
            m_tuser_next  = req_user[sel];
            m_tlast_next  = in_last;
            m_tvalid_next = 1'b1;
        end else if (m_axis_tready) begin
            m_tvalid_next = 1'b0;
        end
    end

    always_comb begin
        pkt_cnt0_next = pkt_cnt0_reg + {31'd0, req_xfer[0] & req_last[0]};
        pkt_cnt1_next = pkt_cnt1_reg + {31'd0, req_xfer[1] & req_last[1]};
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            m_tdata_reg    <= '0;
            m_tkeep_reg    <= '0;
            m_tuser_reg    <= '0;
            m_tvalid_reg   <= 1'b0;
            m_tlast_reg    <= 1'b0;
            pkt_cnt0_reg   <= '0;
            pkt_cnt1_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            m_tdata_reg    <= m_tdata_next;
            m_tkeep_reg    <= m_tkeep_next;
            m_tuser_reg    <= m_tuser_next;
            m_tvalid_reg   <= m_tvalid_next;
            m_tlast_reg    <= m_tlast_next;
            pkt_cnt0_reg   <= pkt_cnt0_next;
            pkt_cnt1_reg   <= pkt_cnt1_next;
        end
    end

    assign m_axis_tdata  = m_tdata_reg;
    assign m_axis_tkeep  = m_tkeep_reg;
    assign m_axis_tuser  = m_tuser_reg;
    assign m_axis_tvalid = m_tvalid_reg;
    assign m_axis_tlast  = m_tlast_reg;
    assign pkt_cnt0      = pkt_cnt0_reg;
    assign pkt_cnt1      = pkt_cnt1_reg;

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Directed bench for pkt_rr_arbiter: queued packet sources per requester, an
// output monitor logging accepted beats, and hand-derived expectations.
`timescale 1ns/1ps
module tb_pkt_rr_arbiter;

    localparam int DW = 256;
    localparam int KW = DW / 8;
    localparam int UW = 128;

    logic            clk = 1'b0;
    logic            aresetn = 1'b1;
    logic [DW-1:0]   sd [2];
    logic [KW-1:0]   sk [2];
    logic [UW-1:0]   su [2];
    logic            sv [2] = '{1'b0, 1'b0};
    logic            sl [2] = '{1'b0, 1'b0};
    logic            srdy [2];
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic [UW-1:0]   m_tuser;
    logic            m_tvalid, m_tlast;
    logic            m_tready = 1'b0;
    logic [31:0]     pkt_cnt0, pkt_cnt1;

    always #5 clk = ~clk;

    pkt_rr_arbiter #(.C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW)) dut (
        .clk(clk), .aresetn(aresetn),
        .s0_axis_tdata(sd[0]), .s0_axis_tkeep(sk[0]), .s0_axis_tuser(su[0]),
        .s0_axis_tvalid(sv[0]), .s0_axis_tlast(sl[0]), .s0_axis_tready(srdy[0]),
        .s1_axis_tdata(sd[1]), .s1_axis_tkeep(sk[1]), .s1_axis_tuser(su[1]),
        .s1_axis_tvalid(sv[1]), .s1_axis_tlast(sl[1]), .s1_axis_tready(srdy[1]),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
        .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
        .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
    );

    typedef struct { int id; bit last; int gap; } sbeat_t;
    typedef struct { int id; bit last; } ebeat_t;
    typedef struct { logic [DW-1:0] d; logic [KW-1:0] k; logic [UW-1:0] u; logic l; int stamp; } rbeat_t;

    sbeat_t  stim [2][128];
    int      wr [2] = '{0, 0};
    int      rd [2] = '{0, 0};
    bit      hs [2];
    bit      loaded [2];
    int      gapc [2];
    rbeat_t  rx [$];
    ebeat_t  exp_q [$];
    int      base;
    int      cyc = 0;
    int      errors = 0;
    int      checks = 0;

    // Beat payloads are pure functions of a beat id, so expectations need only the id
    function automatic logic [DW-1:0] d_of(input int id);
        return {8{32'(id)}};
    endfunction
    function automatic logic [KW-1:0] k_of(input int id);
        return 32'hFFFF_FFFF >> (id % 8);
    endfunction
    function automatic logic [UW-1:0] u_of(input int id);
        return {4{~32'(id)}};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Packet sources: handshake seen at negedge, next beat presented 2ns after posedge
    always begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) hs[i] = sv[i] & srdy[i];
        @(posedge clk);
        #2;
        for (int i = 0; i < 2; i++) begin
            if (!aresetn) begin
                rd[i] = wr[i];
                loaded[i] = 1'b0;
                sv[i] = 1'b0;
            end else begin
                if (hs[i]) begin
                    rd[i] = rd[i] + 1;
                    loaded[i] = 1'b0;
                end
                if (rd[i] != wr[i]) begin
                    if (!loaded[i]) begin
                        gapc[i] = stim[i][rd[i]].gap;
                        loaded[i] = 1'b1;
                    end
                    if (gapc[i] > 0) begin
                        sv[i] = 1'b0;
                        gapc[i] = gapc[i] - 1;
                    end else begin
                        sv[i] = 1'b1;
                        sd[i] = d_of(stim[i][rd[i]].id);
                        sk[i] = k_of(stim[i][rd[i]].id);
                        su[i] = u_of(stim[i][rd[i]].id);
                        sl[i] = stim[i][rd[i]].last;
                    end
                end else begin
                    sv[i] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (aresetn && m_tvalid && m_tready) begin
            rx.push_back('{m_tdata, m_tkeep, m_tuser, m_tlast, cyc});
            $display("rx cyc=%0d data=%08h keep=%08h last=%0b", cyc, m_tdata[31:0], m_tkeep, m_tlast);
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic push(input int src, input int pkt, input int nb, input int gap_at, input int gap_len);
        for (int b = 0; b < nb; b++) begin
            stim[src][wr[src]].id   = src * 1000 + pkt * 10 + b;
            stim[src][wr[src]].last = (b == nb - 1);
            stim[src][wr[src]].gap  = (b == gap_at) ? gap_len : 0;
            wr[src] = wr[src] + 1;
        end
    endtask

    task automatic exp_pkt(input int src, input int pkt, input int nb);
        for (int b = 0; b < nb; b++)
            exp_q.push_back('{src * 1000 + pkt * 10 + b, (b == nb - 1)});
    endtask

    task automatic wait_rx(input int n, input string tag);
        int c = 0;
        while (rx.size() - base < n && c < 200) begin
            tick();
            c++;
        end
        if (rx.size() - base < n) chk({tag, " timeout"}, rx.size() - base, n);
    endtask

    task automatic check_rx(input string tag);
        chk({tag, " count"}, rx.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size() && base + i < rx.size(); i++) begin
            chk($sformatf("%s b%0d data", tag, i), rx[base + i].d, d_of(exp_q[i].id));
            chk($sformatf("%s b%0d keep", tag, i), rx[base + i].k, k_of(exp_q[i].id));
            chk($sformatf("%s b%0d user", tag, i), rx[base + i].u, u_of(exp_q[i].id));
            chk($sformatf("%s b%0d last", tag, i), rx[base + i].l, exp_q[i].last);
        end
    endtask

    task automatic start_case();
        aresetn = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
        m_tready = 1'b1;
        base = rx.size();
        exp_q.delete();
        tick();
    endtask

    initial begin
        int c0;
        #1 aresetn = 1'b0;
        tick();
        tick();
        chk("rst tvalid", m_tvalid, 0);
        chk("rst tdata", m_tdata, 0);
        chk("rst tkeep", m_tkeep, 0);
        chk("rst tuser", m_tuser, 0);
        chk("rst tlast", m_tlast, 0);
        chk("rst s0 tready", srdy[0], 0);
        chk("rst s1 tready", srdy[1], 0);
        chk("rst cnt0", pkt_cnt0, 0);
        chk("rst cnt1", pkt_cnt1, 0);

        // Simultaneous 3-beat packets: s0 wins the first tie, one bubble, then s1
        start_case();
        c0 = cyc;
        push(0, 1, 3, -1, 0);
        push(1, 1, 3, -1, 0);
        exp_pkt(0, 1, 3);
        exp_pkt(1, 1, 3);
        wait_rx(6, "tie");
        repeat (4) tick();
        check_rx("tie");
        if (rx.size() >= base + 6) begin
            chk("tie latency", rx[base].stamp - c0, 3);
            chk("tie gap", rx[base + 3].stamp - rx[base + 2].stamp, 2);
        end
        chk("tie cnt0", pkt_cnt0, 1);
        chk("tie cnt1", pkt_cnt1, 1);

        // Back-to-back 2-beat packets from s1 alone
        start_case();
        for (int p = 0; p < 4; p++) begin
            push(1, p, 2, -1, 0);
            exp_pkt(1, p, 2);
        end
        wait_rx(8, "b2b");
        repeat (4) tick();
        check_rx("b2b");
        if (rx.size() >= base + 8) begin
            for (int p = 0; p < 4; p++)
                chk($sformatf("b2b intra p%0d", p), rx[base + 2 * p + 1].stamp - rx[base + 2 * p].stamp, 1);
            for (int p = 1; p < 4; p++)
                chk($sformatf("b2b gap p%0d", p), rx[base + 2 * p].stamp - rx[base + 2 * p - 1].stamp, 2);
        end
        chk("b2b cnt1", pkt_cnt1, 4);
        chk("b2b cnt0", pkt_cnt0, 0);

        // Output stall of 5 cycles while beat 2 of a 6-beat packet is held
        start_case();
        push(0, 1, 6, -1, 0);
        exp_pkt(0, 1, 6);
        wait_rx(2, "bp");
        m_tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp hold%0d data", k), m_tdata, d_of(12));
            chk($sformatf("bp hold%0d keep", k), m_tkeep, k_of(12));
            chk($sformatf("bp hold%0d user", k), m_tuser, u_of(12));
            chk($sformatf("bp hold%0d tvalid", k), m_tvalid, 1);
            chk($sformatf("bp hold%0d s0 tready", k), srdy[0], 0);
        end
        tick();
        m_tready = 1'b1;
        wait_rx(6, "bp");
        repeat (4) tick();
        check_rx("bp");
        chk("bp cnt0", pkt_cnt0, 1);

        // s0 pauses 3 cycles mid-packet with s1 waiting; s1 then wins the next tie
        start_case();
        push(0, 1, 4, 2, 3);
        push(0, 2, 2, -1, 0);
        push(1, 1, 2, -1, 0);
        exp_pkt(0, 1, 4);
        exp_pkt(1, 1, 2);
        exp_pkt(0, 2, 2);
        wait_rx(8, "drop");
        repeat (4) tick();
        check_rx("drop");
        if (rx.size() >= base + 3)
            chk("drop pause", rx[base + 2].stamp - rx[base + 1].stamp, 4);
        chk("drop cnt0", pkt_cnt0, 2);
        chk("drop cnt1", pkt_cnt1, 1);

        // Counter wrap
        start_case();
        force dut.pkt_cnt0_reg = 32'hFFFF_FFFF;
        tick();
        release dut.pkt_cnt0_reg;
        tick();
        chk("wrap preset", pkt_cnt0, 32'hFFFF_FFFF);
        push(0, 1, 1, -1, 0);
        exp_pkt(0, 1, 1);
        wait_rx(1, "wrap");
        repeat (3) tick();
        check_rx("wrap");
        chk("wrap cnt0", pkt_cnt0, 0);

        // Reset while beat 2 of 4 sits in the output register
        start_case();
        push(0, 1, 4, -1, 0);
        wait_rx(1, "mrst");
        aresetn = 1'b0;
        #1;
        chk("mrst tvalid", m_tvalid, 0);
        chk("mrst tdata", m_tdata, 0);
        chk("mrst tlast", m_tlast, 0);
        chk("mrst s0 tready", srdy[0], 0);
        tick();
        tick();
        aresetn = 1'b1;
        tick();
        exp_q.push_back('{10, 1'b0});
        push(0, 2, 3, -1, 0);
        exp_pkt(0, 2, 3);
        wait_rx(4, "mrst");
        repeat (4) tick();
        check_rx("mrst");
        chk("mrst cnt0", pkt_cnt0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pkt_rr_arbiter.md
PKT_RR_ARBITER -- requirements
Module: pkt_rr_arbiter

Interface
REQ-001 SHALL have parameter C_S_AXIS_DATA_WIDTH, default 256, the AXI-Stream data width in bits.
REQ-002 SHALL have parameter C_S_AXIS_TUSER_WIDTH, default 128, the AXI-Stream tuser width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the clock; all logic is on its rising edge.
REQ-004 SHALL have port aresetn, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have ports s0_axis_tdata/tkeep/tuser/tvalid/tlast, inputs, widths DATA/DATA/8/TUSER/1/1: requester 0 stream.
REQ-006 SHALL have port s0_axis_tready, output, 1 bit: requester 0 ready.
REQ-007 SHALL have ports s1_axis_tdata/tkeep/tuser/tvalid/tlast, inputs, same widths as REQ-005: requester 1 stream.
REQ-008 SHALL have port s1_axis_tready, output, 1 bit: requester 1 ready.
REQ-009 SHALL have ports m_axis_tdata/tkeep/tuser/tvalid/tlast, registered outputs, same widths as REQ-005: merged stream.
REQ-010 SHALL have port m_axis_tready, input, 1 bit: downstream ready.
REQ-011 SHALL have ports pkt_cnt0 and pkt_cnt1, registered outputs, 32 bits each: packets forwarded per requester.

Function
REQ-012 SHALL arbitrate at packet granularity; a grant is held from the first beat through the tlast beat.
REQ-013 SHALL implement the states IDLE, GRANT0 and GRANT1.
REQ-014 SHALL keep a last_grant bit recording the most recently completed requester.
REQ-015 SHALL, in IDLE with exactly one sk_axis_tvalid high, move to GRANTk the next cycle.
REQ-016 SHALL, in IDLE with both tvalid high, move to the GRANT state of the requester not equal to last_grant.
REQ-017 SHALL, in IDLE, hold both sk_axis_tready at 0 (one-cycle arbitration bubble).
REQ-018 SHALL, in GRANTk, drive sk_axis_tready = ~m_axis_tvalid | m_axis_tready and hold the other tready at 0.
REQ-019 SHALL, on a GRANTk input transfer (tvalid & tready), load all m_axis_* registers from sk on the next edge and set m_axis_tvalid=1.
REQ-020 SHALL, on an output transfer with no simultaneous input transfer, clear m_axis_tvalid; data fields may hold.
REQ-021 SHALL, while m_axis_tvalid=1 and m_axis_tready=0, hold every m_axis_* output stable.
REQ-022 SHALL, on a GRANTk input transfer with tlast=1, go to IDLE, set last_grant=k, and increment pkt_cnt_k.
REQ-023 SHALL make pkt_cnt wrap from 0xFFFFFFFF to 0.
REQ-024 SHALL, if the granted tvalid drops mid-packet, stay in GRANTk; m_axis_tvalid falls after the pending beat drains, and no beat is inserted from the other requester.
REQ-025 SHALL, with the other requester valid at the same edge as the tlast transfer, still pass through IDLE before granting.
REQ-026 SHALL have a forwarding latency of 1 cycle from input transfer to m_axis_tvalid.
REQ-027 SHALL sustain full throughput within a packet while m_axis_tready=1.

Reset
REQ-028 SHALL, on reset assertion, immediately force state=IDLE, last_grant=1 (requester 0 wins the first tie), all m_axis_* = 0, both tready = 0, and both pkt_cnt = 0.
REQ-029 SHALL, on reset mid-packet, discard the partial packet with no recovery, then resume arbitration from IDLE.

Verification
REQ-030 SHALL verify: both requesters present 3-beat packets from reset, with m_axis_tready=1 -> s0 packet (beats D0..D2), one idle cycle, s1 packet; pkt_cnt0=1, pkt_cnt1=1.
REQ-031 SHALL verify: s1 streams back-to-back 2-beat packets while s0 is idle -> every s1 packet is forwarded, with a 1-cycle gap between packets; pkt_cnt1 counts 4 after 4 packets.
REQ-032 SHALL verify: m_axis_tready is held low for 5 cycles mid-packet -> m_axis outputs stay stable, granted tready=0, no beat is lost or duplicated, and tkeep/tuser match the input per beat.
REQ-033 SHALL verify: s0 drops tvalid for 3 cycles mid-packet while s1 is valid -> s1 gets no grant until the s0 tlast beat is transferred.
REQ-034 SHALL verify: pkt_cnt0 is forced to 0xFFFFFFFF and one s0 packet is completed -> pkt_cnt0=0.
REQ-035 SHALL verify: aresetn is pulsed low during beat 2 of 4 -> outputs are 0 the same cycle, and the next packet after release is forwarded intact.
